// File: rtl/dds_pkg.sv
// dds_pkg -- shared definitions for the DDS frequency sweep controller.
//
// Holds the sweep state enumeration and the default code and dwell widths.
// Optional feature macro: DDS_SWEEP_BIDIR_EN adds the DOWN state used for
// triangle (up then down) sweeping.
package dds_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_DWELL_WIDTH = 16;

  // STEP is the decision taken in the final dwell cycle of a code; it is
  // decoded from DWELL plus the timer zero flag rather than held for a cycle
  // of its own, so every code is held exactly dwell+1 cycles.
`ifdef DDS_SWEEP_BIDIR_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DWELL = 3'd1,
    STEP  = 3'd2,
    DONE  = 3'd3,
    DOWN  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DWELL = 3'd1,
    STEP  = 3'd2,
    DONE  = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer -- loadable down-counter timing how long each code is held.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load      load value into the counter this cycle (takes priority)
//   value     count to load (the dwell setting)
//   zero      high while the counter is 0 (final cycle of the hold)
module dds_dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] value,
  output logic                   zero
);

  logic [DWELL_WIDTH-1:0] count;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl -- stepped frequency-code sweep generator feeding a DDS
// phase accumulator.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start            launch a sweep (accepted only while idle)
//   abort            end the current sweep at once, no done pulse
//   start_code       first code of the sweep
//   stop_code        final code of the sweep (clamp target)
//   step_code        increment applied per step
//   dwell            extra hold cycles per code (hold = dwell+1)
//   repeat_mode      restart from start_code after each pass until aborted
//   code             registered frequency code
//   busy             sweep in progress
//   step_strobe      one-cycle pulse whenever code is (re)loaded
//   done             one-cycle pulse when a non-repeating sweep finishes
//
// Optional feature macro: DDS_SWEEP_BIDIR_EN -- after holding stop_code the
// sweep descends by step_code back to start_code (triangle sweep).
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DWELL_WIDTH = DEFAULT_DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       start_code,
  input  logic [WIDTH-1:0]       stop_code,
  input  logic [WIDTH-1:0]       step_code,
  input  logic [DWELL_WIDTH-1:0] dwell,
  input  logic                   repeat_mode,
  output logic [WIDTH-1:0]       code,
  output logic                   busy,
  output logic                   step_strobe,
  output logic                   done
);

  state_t state_q, state_d, phase;

  logic [WIDTH-1:0]       code_q, code_d;
  logic                   busy_q, busy_d;
  logic                   strobe_q, strobe_d;
  logic                   done_q, done_d;
  logic                   last_q, last_d;   // current code ends this leg

  // Configuration captured at start; inputs are don't-care afterwards.
  logic [WIDTH-1:0]       start_c, stop_c, step_c;
  logic [DWELL_WIDTH-1:0] dwell_c;
  logic                   repeat_c;
  logic                   single_c;         // single-point sweep

  logic                   capture;
  logic                   single_in;
  logic                   leg_end;
  logic                   load;
  logic [DWELL_WIDTH-1:0] load_value;
  logic                   timer_zero;

  logic [WIDTH:0]         sum;
  logic                   up_clamp;

  dds_dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .value(load_value),
    .zero (timer_zero)
  );

  assign capture   = (state_q == IDLE) && start && !abort;
  assign single_in = (step_code == '0) || (start_code >= stop_code);

  // The extra carry bit keeps a step past the top of the code range from
  // wrapping around to a small value.
  assign sum      = {1'b0, code_q} + {1'b0, step_c};
  assign up_clamp = sum[WIDTH] || (sum[WIDTH-1:0] >= stop_c);

`ifdef DDS_SWEEP_BIDIR_EN
  logic [WIDTH:0] diff;
  logic           dn_clamp;

  // Borrow out of the extra bit marks a step below zero.
  assign diff     = {1'b0, code_q} - {1'b0, step_c};
  assign dn_clamp = diff[WIDTH] || (diff[WIDTH-1:0] <= start_c);
`endif

  assign phase = (state_q == DWELL && timer_zero) ? STEP : state_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    busy_d     = busy_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    last_d     = last_q;
    load       = 1'b0;
    load_value = dwell_c;
    leg_end    = 1'b0;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (phase)
        IDLE: begin
          if (capture) begin
            state_d    = DWELL;
            code_d     = start_code;
            busy_d     = 1'b1;
            strobe_d   = 1'b1;
            last_d     = single_in;
            load       = 1'b1;
            load_value = dwell;
          end
        end
        DWELL: ;
        STEP: begin
          if (!last_q) begin
            code_d   = up_clamp ? stop_c : sum[WIDTH-1:0];
            last_d   = up_clamp;
            strobe_d = 1'b1;
            load     = 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          end else if (!single_c) begin
            // stop_code hold finished: start the descending leg.
            state_d  = DOWN;
            code_d   = dn_clamp ? start_c : diff[WIDTH-1:0];
            last_d   = dn_clamp;
            strobe_d = 1'b1;
            load     = 1'b1;
`endif
          end else begin
            leg_end = 1'b1;
          end
        end
`ifdef DDS_SWEEP_BIDIR_EN
        DOWN: begin
          if (timer_zero) begin
            if (!last_q) begin
              code_d   = dn_clamp ? start_c : diff[WIDTH-1:0];
              last_d   = dn_clamp;
              strobe_d = 1'b1;
              load     = 1'b1;
            end else begin
              leg_end = 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase

      if (leg_end) begin
        if (repeat_c) begin
          state_d  = DWELL;
          code_d   = start_c;
          last_d   = single_c;
          strobe_d = 1'b1;
          load     = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // NOTE: the captured configuration is reset along with the control state so
  // nothing left over from an interrupted sweep is visible after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
      start_c  <= '0;
      stop_c   <= '0;
      step_c   <= '0;
      dwell_c  <= '0;
      repeat_c <= 1'b0;
      single_c <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      last_q   <= last_d;
      if (capture) begin
        start_c  <= start_code;
        stop_c   <= stop_code;
        step_c   <= step_code;
        dwell_c  <= dwell;
        repeat_c <= repeat_mode;
        single_c <= single_in;
      end
    end
  end

  assign code        = code_q;
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, frequency-code width; matches the phase-accumulator code input it drives.
REQ-002 Parameter DWELL_WIDTH, default 16, dwell counter width.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port start  input  1  single-cycle sweep launch request.
REQ-006 Port abort  input  1  terminate current sweep.
REQ-007 Port start_code  input  WIDTH  first code of sweep.
REQ-008 Port stop_code  input  WIDTH  final code of sweep.
REQ-009 Port step_code  input  WIDTH  code increment per step.
REQ-010 Port dwell  input  DWELL_WIDTH  extra cycles each code is held (hold time = dwell+1 cycles).
REQ-011 Port repeat_mode  input  1  1 = restart sweep after completion until abort.
REQ-012 Port code  output  WIDTH  registered frequency code to the phase accumulator.
REQ-013 Port busy  output  1  high while a sweep is active.
REQ-014 Port step_strobe  output  1  one-cycle pulse in the cycle a new code value appears on code.
REQ-015 Port done  output  1  one-cycle pulse on non-repeat sweep completion.

Function
REQ-016 States: IDLE, DWELL, STEP, DONE (plus DOWN when REQ-032 is enabled); all registers clocked by clk.
REQ-017 start sampled in IDLE: configuration inputs captured into internal registers; next cycle code=start_code, busy=1, step_strobe=1, state DWELL; latency exactly 1 cycle.
REQ-018 Configuration inputs are ignored after capture; changes mid-sweep take effect only at the next start.
REQ-019 DWELL: dwell counter loads dwell on each new code, decrements per cycle; at 0 go to STEP, so each code is held dwell+1 cycles.
REQ-020 STEP: next = code + step_code computed in WIDTH+1 bits; if carry set or next >= stop_code, code=stop_code and this is the last step; else code=next; step_strobe=1; back to DWELL.
REQ-021 After the dwell of the stop_code step: repeat_mode=1 -> code=start_code, step_strobe=1, DWELL; repeat_mode=0 -> DONE.
REQ-022 DONE lasts one cycle: done=1, busy goes 0 the following cycle, state IDLE; code holds stop_code.
REQ-023 step_code=0 or start_code>=stop_code: single-point sweep; code=start_code held dwell+1 cycles, then REQ-021 applies (no second code step).
REQ-024 start while busy=1 is ignored.
REQ-025 abort in any non-IDLE state: IDLE next cycle, busy=0, no done pulse, code holds its current value.
REQ-026 start and abort in the same cycle: abort wins; no sweep starts.
REQ-027 repeat_mode repeats indefinitely; only abort or rst ends it.

Reset
REQ-028 rst asserted: state=IDLE, code=0, busy=0, step_strobe=0, done=0, dwell counter=0, captured config=0, immediately and asynchronously.
REQ-029 rst mid-sweep discards the sweep; no done pulse on or after reset release.
REQ-030 First start is accepted in the first clock edge after rst deasserts.

Configuration
REQ-031 Macro DDS_SWEEP_BIDIR_EN selects triangle sweeping.
REQ-032 With DDS_SWEEP_BIDIR_EN: after stop_code dwell, state DOWN steps code = code - step_code (WIDTH+1-bit borrow check), clamped to start_code when borrow or result <= start_code; REQ-021 is then applied at start_code instead of stop_code; done leaves code=start_code.
REQ-033 Without DDS_SWEEP_BIDIR_EN: DOWN state and subtractor are absent; behaviour is REQ-020..REQ-022 only.

Structure
REQ-034 Shared package dds_pkg holds the state enumeration and the default WIDTH and DWELL_WIDTH constants.
REQ-035 One sub-module, dds_dwell_timer (load, count-down, zero flag), instantiated once; remainder is inline.

Verification
REQ-036 WIDTH=16, start=1000, stop=1300, step=100, dwell=2, repeat=0 -> code 1000,1100,1200,1300 each held 3 cycles, 4 step_strobes, done one cycle after last hold, busy low next cycle.
REQ-037 start=1000, stop=1250, step=100, dwell=0 -> codes 1000,1100,1200,1250 (clamp), done after 4 cycles.
REQ-038 start=65000, stop=65535, step=1000 -> codes 65000,65535 (carry clamp, no wrap), done.
REQ-039 repeat=1, start=0, stop=200, step=100, dwell=1; abort after second 0 appears -> sequence 0,100,200,0 then busy=0 next cycle, no done, code holds 0; start+abort same cycle -> busy stays 0.
REQ-040 rst asserted in DWELL with code=1100 -> code=0, busy=0 without a clock edge; start with stop<=start (start=500, stop=400) -> code 500 for dwell+1 cycles, done.
REQ-041 With DDS_SWEEP_BIDIR_EN: start=0, stop=300, step=100, dwell=0 -> 0,100,200,300,200,100,0, done, code=0.
